// File: rtl/led8_seq.sv
// LED8 pattern sequencer: prescaled step engine feeding led8pwm with a pattern
// (count, scanner, breathe, rotate) and a global brightness value.
module led8_seq #(
  parameter int unsigned TICK_DIV     = 2400000,
  parameter int unsigned VAL_FIXED    = 128,
  parameter int unsigned BREATHE_STEP = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode,
  input  logic       pause,
  output logic [7:0] led,
  output logic [7:0] val,
  output logic       tick
);

  localparam int unsigned DivW = $clog2(TICK_DIV);
  localparam logic [DivW-1:0] DivLast  = DivW'(TICK_DIV - 1);
  localparam logic [7:0]      ValFixed = 8'(VAL_FIXED);
  localparam logic [8:0]      BStep    = 9'(BREATHE_STEP);

  typedef enum logic [1:0] {
    ModeCount   = 2'd0,
    ModeScan    = 2'd1,
    ModeBreathe = 2'd2,
    ModeRotate  = 2'd3
  } mode_e;

  logic [DivW-1:0] div_q, div_d;
  mode_e           cur_mode_q, cur_mode_d;
  logic            dir_q, dir_d;
  logic [7:0]      led_q, led_d;
  logic [7:0]      val_q, val_d;
  logic            tick_q, tick_d;
  logic            step;
  logic [8:0]      val_sum;

  assign step    = (div_q == DivLast);
  assign val_sum = {1'b0, val_q} + BStep;

  always_comb begin
    div_d      = div_q;
    cur_mode_d = cur_mode_q;
    dir_d      = dir_q;
    led_d      = led_q;
    val_d      = val_q;
    tick_d     = 1'b0;

    if (mode_e'(mode) != cur_mode_q) begin
      // Mode change wins over pause and step, and restarts the animation.
      cur_mode_d = mode_e'(mode);
      div_d      = '0;
      dir_d      = 1'b1;
      unique case (mode_e'(mode))
        ModeCount:   begin led_d = 8'h00; val_d = ValFixed; end
        ModeScan:    begin led_d = 8'h01; val_d = ValFixed; end
        ModeBreathe: begin led_d = 8'hFF; val_d = 8'h00;    end
        ModeRotate:  begin led_d = 8'h03; val_d = ValFixed; end
        default:     ;
      endcase
    end else if (!pause) begin
      div_d  = step ? '0 : div_q + 1'b1;
      tick_d = step;
      if (step) begin
        unique case (cur_mode_q)
          ModeCount: led_d = led_q + 8'd1;
          ModeScan: begin
            if (dir_q && led_q == 8'h80) begin
              led_d = 8'h40;
              dir_d = 1'b0;
            end else if (!dir_q && led_q == 8'h01) begin
              led_d = 8'h02;
              dir_d = 1'b1;
            end else if (dir_q) begin
              led_d = led_q << 1;
            end else begin
              led_d = led_q >> 1;
            end
          end
          ModeBreathe: begin
            led_d = 8'hFF;
            // Saturate at both ends and reverse direction there.
            if (dir_q) begin
              if (val_sum >= 9'd255) begin
                val_d = 8'hFF;
                dir_d = 1'b0;
              end else begin
                val_d = val_sum[7:0];
              end
            end else if ({1'b0, val_q} <= BStep) begin
              val_d = 8'h00;
              dir_d = 1'b1;
            end else begin
              val_d = val_q - BStep[7:0];
            end
          end
          ModeRotate: led_d = {led_q[6:0], led_q[7]};
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q      <= '0;
      cur_mode_q <= ModeCount;
      dir_q      <= 1'b1;
      led_q      <= 8'h00;
      val_q      <= ValFixed;
      tick_q     <= 1'b0;
    end else begin
      div_q      <= div_d;
      cur_mode_q <= cur_mode_d;
      dir_q      <= dir_d;
      led_q      <= led_d;
      val_q      <= val_d;
      tick_q     <= tick_d;
    end
  end

  assign led  = led_q;
  assign val  = val_q;
  assign tick = tick_q;

endmodule

// File: tb/tb_led8_seq.sv
// Self-checking bench for led8_seq: a step-count model derives the expected
// pattern and brightness directly from the animation rules.
module tb_led8_seq;

  localparam int unsigned TD = 4;
  localparam int unsigned VF = 128;
  localparam int unsigned BS = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] mode = 2'd0;
  logic       pause = 1'b0;
  logic [7:0] led, val;
  logic       tick;

  int n_chk = 0;
  int n_err = 0;

  // Model state: mode in effect, un-paused edges and steps since mode entry.
  logic [1:0] m_mode = 2'd0;
  int         m_phase = 0;
  int         m_steps = 0;
  logic       m_tick = 1'b0;

  led8_seq #(
    .TICK_DIV    (TD),
    .VAL_FIXED   (VF),
    .BREATHE_STEP(BS)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .mode (mode),
    .pause(pause),
    .led  (led),
    .val  (val),
    .tick (tick)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_led();
    int k, x;
    k = m_steps;
    case (m_mode)
      2'd0: return 8'(k % 256);
      2'd1: begin
        x = k % 14;
        if (x > 7) x = 14 - x;
        return 8'(1 << x);
      end
      2'd2: return 8'hFF;
      default: begin
        x = 3 << (k % 8);
        return 8'((x | (x >> 8)) & 255);
      end
    endcase
  endfunction

  function automatic logic [7:0] exp_val();
    int v;
    bit up;
    if (m_mode != 2'd2) return 8'(VF);
    v  = 0;
    up = 1;
    for (int i = 0; i < m_steps; i++) begin
      if (up) begin
        if (v + BS >= 255) begin v = 255; up = 0; end
        else v = v + BS;
      end else begin
        if (v <= BS) begin v = 0; up = 1; end
        else v = v - BS;
      end
    end
    return 8'(v);
  endfunction

  task automatic model_reset();
    m_mode  = 2'd0;
    m_phase = 0;
    m_steps = 0;
    m_tick  = 1'b0;
  endtask

  // Advance one clock edge, update the model, leave time 1 after the edge.
  task automatic cycle();
    @(posedge clk);
    if (rst) model_reset();
    else if (mode != m_mode) begin
      m_mode  = mode;
      m_phase = 0;
      m_steps = 0;
      m_tick  = 1'b0;
    end else if (pause) begin
      m_tick = 1'b0;
    end else begin
      m_phase++;
      if (m_phase % TD == 0) begin
        m_steps++;
        m_tick = 1'b1;
      end else begin
        m_tick = 1'b0;
      end
    end
    #1;
  endtask

  task automatic run_and_check(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      cycle();
      n_chk++;
      if ({led, val, tick} !== {exp_led(), exp_val(), m_tick}) begin
        n_err++;
        $display("FAIL %s cyc=%0d: led=%h val=%0d tick=%b, required led=%h val=%0d tick=%b",
                 name, i, led, val, tick, exp_led(), exp_val(), m_tick);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mode = 2'd0;
    pause = 1'b0;
    cycle();
    cycle();
    n_chk++;
    if ({led, val, tick} !== {8'h00, 8'd128, 1'b0}) begin
      n_err++;
      $display("FAIL reset_state: led=%h val=%0d tick=%b, required 00/128/0", led, val, tick);
    end
    rst = 1'b0;
    model_reset();
    for (int i = 1; i <= 8; i++) begin
      cycle();
      n_chk++;
      if (i == 4 && {led, tick} !== {8'h01, 1'b1}) begin
        n_err++;
        $display("FAIL first_step: led=%h tick=%b, required 01/1", led, tick);
      end else if (i == 8 && {led, tick} !== {8'h02, 1'b1}) begin
        n_err++;
        $display("FAIL second_step: led=%h tick=%b, required 02/1", led, tick);
      end else if (i != 4 && i != 8 && tick !== 1'b0) begin
        n_err++;
        $display("FAIL no_tick_between: edge=%0d tick=%b, required 0", i, tick);
      end
    end
  endtask

  task automatic test_count();
    run_and_check("count_wrap", 256 * TD + 8);
  endtask

  task automatic test_scanner();
    mode = 2'd1;
    run_and_check("scanner", 16 * TD + 4);
  endtask

  task automatic test_breathe();
    mode = 2'd2;
    run_and_check("breathe", 10 * TD + 1);
  endtask

  task automatic test_rotate();
    mode = 2'd3;
    run_and_check("rotate", 10 * TD + 1);
  endtask

  task automatic test_mode_change();
    mode = 2'd3;
    cycle();
    run_and_check("mc_pre", 2);
    mode = 2'd1;
    cycle();
    n_chk++;
    if ({led, val, tick} !== {8'h01, 8'd128, 1'b0}) begin
      n_err++;
      $display("FAIL mode_change_load: led=%h val=%0d tick=%b, required 01/128/0",
               led, val, tick);
    end
    run_and_check("mc_after", TD + 1);
    pause = 1'b1;
    mode = 2'd2;
    cycle();
    n_chk++;
    if ({led, val, tick} !== {8'hFF, 8'h00, 1'b0}) begin
      n_err++;
      $display("FAIL mode_change_paused: led=%h val=%0d tick=%b, required FF/0/0",
               led, val, tick);
    end
    pause = 1'b0;
    run_and_check("mc_resume", TD + 1);
  endtask

  task automatic test_pause();
    logic [7:0] hl, hv;
    mode = 2'd0;
    cycle();
    run_and_check("pause_pre", 1);
    hl = exp_led();
    hv = exp_val();
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      n_chk++;
      if ({led, val, tick} !== {hl, hv, 1'b0}) begin
        n_err++;
        $display("FAIL pause_hold cyc=%0d: led=%h val=%0d tick=%b, required %h/%0d/0",
                 i, led, val, tick, hl, hv);
      end
    end
    pause = 1'b0;
    run_and_check("pause_resume", 2 * TD);
  endtask

  task automatic test_async_reset();
    mode = 2'd2;
    cycle();
    run_and_check("ar_pre", 2 * TD);
    n_chk++;
    if (val !== 8'd200) begin
      n_err++;
      $display("FAIL ar_setup: val=%0d, required 200", val);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    n_chk++;
    if ({led, val, tick} !== {8'h00, 8'd128, 1'b0}) begin
      n_err++;
      $display("FAIL async_reset: led=%h val=%0d tick=%b, required 00/128/0", led, val, tick);
    end
    cycle();
    @(negedge clk);
    rst = 1'b0;
    run_and_check("ar_release", 2 * TD + 1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 24) == 0) mode = 2'($urandom_range(0, 3));
      pause = ($urandom_range(0, 7) == 0);
      run_and_check("random", 1);
    end
    pause = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count();
    test_scanner();
    test_breathe();
    test_rotate();
    test_mode_change();
    test_pause();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
